mux2to1_block: RTL and testbench

MUX2TO1_BLOCK -- requirements
Module: mux2to1

---
 rtl/mux2to1_block_if.sv | 33 +++
 rtl/mux2to1_block.sv | 49 ++++
 tb/tb_mux2to1_block.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mux2to1_block_if.sv
// rtl/mux2to1_block_if.sv - mux data/select bundle with master (driver) and slave (mux) views
interface mux2to1_block_if #(
    parameter int WIDTH = 1
) (
    input logic clk
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Y_q;
    logic [7:0]       sel_chg_cnt;

    modport master (
        input  clk,
        output A,
        output B,
        output C,
        input  Y,
        input  Y_q,
        input  sel_chg_cnt
    );

    modport slave (
        input  clk,
        input  A,
        input  B,
        input  C,
        output Y,
        output Y_q,
        output sel_chg_cnt
    );
endinterface

// File: rtl/mux2to1_block.sv
// rtl/mux2to1_block.sv - 2:1 mux with registered copy and optional select-change counter (MUX2TO1_SELCNT_EN)
module mux2to1_block #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] Y,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] Y_q,
    output logic [7:0]       sel_chg_cnt
);

    // Conditional operator keeps agreeing bits when the select is unknown.
    assign Y = C ? B : A;

    // Registered copy of the mux output, one cycle behind Y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q <= '0;
        end else begin
            Y_q <= Y;
        end
    end

`ifdef MUX2TO1_SELCNT_EN
    logic       C_d;
    logic [7:0] chg_cnt;

    // Track previous select and count edges where it differs, sticking at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C_d     <= 1'b0;
            chg_cnt <= 8'd0;
        end else begin
            C_d <= C;
            if ((C != C_d) && (chg_cnt != 8'hFF)) begin
                chg_cnt <= chg_cnt + 8'd1;
            end
        end
    end

    assign sel_chg_cnt = chg_cnt;
`else
    assign sel_chg_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mux2to1_block.sv
// tb/tb_mux2to1_block.sv - randomized self-checking bench for mux2to1_block against a behavioural model
module tb_mux2to1_block;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   cmp_en;

    mux2to1_block_if #(.WIDTH(8)) bus (.clk(clk));

    logic       y1;
    logic       yq1;
    logic [7:0] cnt1;

    mux2to1_block #(.WIDTH(8)) u_dut (
        .A           (bus.A),
        .B           (bus.B),
        .C           (bus.C),
        .Y           (bus.Y),
        .clk         (clk),
        .rst_n       (rst_n),
        .Y_q         (bus.Y_q),
        .sel_chg_cnt (bus.sel_chg_cnt)
    );

    mux2to1_block #(.WIDTH(1)) u_dut1 (
        .A           (bus.A[0]),
        .B           (bus.B[0]),
        .C           (bus.C),
        .Y           (y1),
        .clk         (clk),
        .rst_n       (rst_n),
        .Y_q         (yq1),
        .sel_chg_cnt (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: expected registered value, total select changes since reset.
    logic [7:0] m_yq;
    int         m_changes;
    logic       m_prev_c;

    initial begin
        m_yq      = 8'd0;
        m_changes = 0;
        m_prev_c  = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_yq      = 8'd0;
            m_changes = 0;
            m_prev_c  = 1'b0;
        end else begin
            m_yq = (bus.A & ~{8{bus.C}}) | (bus.B & {8{bus.C}});
            if (bus.C != m_prev_c) m_changes = m_changes + 1;
            m_prev_c = bus.C;
        end
    end

    function automatic logic [7:0] exp_cnt();
`ifdef MUX2TO1_SELCNT_EN
        return (m_changes > 255) ? 8'd255 : 8'(m_changes);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [7:0] exp_y();
        return (bus.A & ~{8{bus.C}}) | (bus.B & {8{bus.C}});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("y",     32'(bus.Y),           32'(exp_y()));
            chk("y_w1",  32'(y1),              32'(exp_y() & 8'h01));
            chk("y_q",   32'(bus.Y_q),         32'(m_yq));
            chk("y_q_w1",32'(yq1),             32'(m_yq[0]));
            chk("cnt",   32'(bus.sel_chg_cnt), 32'(exp_cnt()));
            chk("cnt_w1",32'(cnt1),            32'(exp_cnt()));
        end
    end

    logic [7:0] sweep_tbl;
    logic [2:0] m;
    logic [7:0] sat_req;

    initial begin
        checks    = 0;
        errors    = 0;
        cmp_en    = 1'b0;
        bus.A     = 8'd0;
        bus.B     = 8'd0;
        bus.C     = 1'b0;
        rst_n     = 1'b1;
        // Y = (A&~C)|(B&C) for {A,B,C} = 0..7
        sweep_tbl = 8'b1101_1000;
`ifdef MUX2TO1_SELCNT_EN
        sat_req = 8'd255;
`else
        sat_req = 8'd0;
`endif

        // Asynchronous reset, observed before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_y_q", 32'(bus.Y_q), 32'h0);
        chk("rst_cnt", 32'(bus.sel_chg_cnt), 32'h0);
        cmp_en = 1'b1;

        // Release, A=1 C=0, one edge loads Y_q.
        @(negedge clk); #1;
        rst_n = 1'b1; bus.A = 8'h01; bus.B = 8'h00; bus.C = 1'b0;
        @(posedge clk); #1;
        chk("first_edge_y_q", 32'(bus.Y_q), 32'h01);
        chk("first_edge_cnt", 32'(bus.sel_chg_cnt), 32'h0);

        // Truth-table sweep on the 1-bit instance.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            m = 3'(i);
            bus.A = {7'd0, m[2]};
            bus.B = {7'd0, m[1]};
            bus.C = m[0];
            #1;
            chk("sweep_y_w1", 32'(y1), 32'(sweep_tbl[i]));
        end

        // Select flip within one time step, no clock edge in between.
        @(negedge clk); #1;
        bus.A = 8'h5A; bus.B = 8'hC3; bus.C = 1'b0;
        #1 chk("sel0_y", 32'(bus.Y), 32'h5A);
        bus.C = 1'b1;
        #1 chk("sel1_y", 32'(bus.Y), 32'hC3);

        // Random traffic checked by the per-cycle compare.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            bus.C = 1'($urandom_range(0, 1));
        end

        // Reset mid-cycle: registers drop at once, Y keeps tracking.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_y_q", 32'(bus.Y_q), 32'h0);
        chk("mid_rst_cnt", 32'(bus.sel_chg_cnt), 32'h0);
        bus.A = 8'hA5; bus.B = 8'h3C; bus.C = 1'b1;
        #1 chk("mid_rst_y", 32'(bus.Y), 32'h3C);
        bus.C = 1'b0;
        #1 chk("mid_rst_y2", 32'(bus.Y), 32'hA5);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Toggle select on 300 edges; counter saturates (or stays 0 when disabled).
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            bus.C = ~bus.C;
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
        end
        @(posedge clk); #1;
        chk("sat_cnt", 32'(bus.sel_chg_cnt), 32'(sat_req));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            bus.C = ~bus.C;
        end
        @(posedge clk); #1;
        chk("sat_hold", 32'(bus.sel_chg_cnt), 32'(sat_req));
        chk("sat_hold_w1", 32'(cnt1), 32'(sat_req));

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
